seq_restoring_divider: RTL and testbench
========================================

// Module: seq_restoring_divider
// PURPOSE
// - Iterative unsigned divider: the inverse of the multiplier datapath (16-bit product from 8-bit operands).
// - Recovers quotient/remainder from a 16-bit dividend and an 8-bit divisor, one (or two) quotient bits per cycle.
// - Sits beside the multiplier in the arithmetic unit; valid/ready on both sides; one operation in flight.
// PARAMETERS
// - DIVIDEND_W  16  dividend and quotient width; must be even
// - DIVISOR_W   8   divisor and remainder width; DIVISOR_W <= DIVIDEND_W
// PORTS
// - clk          in   1           single clock, rising edge
// - rst_n        in   1           asynchronous, active-low reset
// - in_valid     in   1           operand pair valid
// - in_ready     out  1           divider can accept operands
// - dividend     in   DIVIDEND_W  unsigned dividend
// - divisor      in   DIVISOR_W   unsigned divisor
// - out_valid    out  1           result valid; held until out_ready
// - out_ready    in   1           downstream accepts result
// - quotient     out  DIVIDEND_W  unsigned quotient
// - remainder    out  DIVISOR_W   unsigned remainder, always < divisor when divisor != 0
// - div_by_zero  out  1           result produced from divisor == 0
// BEHAVIOUR
// - Reset (async, any state, incl. mid-CALC): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0;
//   div_by_zero=0; iteration counter and partial remainder cleared; in-flight operation discarded.
// - FSM: IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: in_ready=1. Accept on in_valid&&in_ready edge; capture operands.
//     divisor!=0 -> CALC, counter=N. divisor==0 -> DONE directly.
//   - CALC: in_ready=0. Per edge: restoring step(s) MSB-first.
//     Partial remainder is DIVISOR_W+1 bits (one guard bit) so shift-subtract never overflows.
//     Counter decrements; the edge with counter==1 writes quotient/remainder, enters DONE.
//   - DONE: out_valid=1, in_ready=0. Outputs stable while out_ready=0.
//     out_valid&&out_ready edge -> IDLE; out_valid=0 next cycle.
// - N = DIVIDEND_W (radix-2 default). out_valid first high N cycles after the accept edge.
// - Divide-by-zero: quotient = all ones; remainder = dividend[DIVISOR_W-1:0]; div_by_zero=1.
//   out_valid high the cycle after the accept edge.
// - div_by_zero cleared on next accepted operation; quotient/remainder hold last result until overwritten.
// - No accept in the same cycle as result handoff (in_ready low in DONE). Min initiation interval N+2 cycles.
// - in_valid ignored outside IDLE. Operand inputs need only be stable on the accept edge.
// - dividend < divisor: quotient=0, remainder=dividend, full latency N.
// CONFIGURATION
// - Macro RADIX4_EN.
//   - Defined: two restoring steps chained combinationally per CALC edge (2 quotient bits/cycle); N = DIVIDEND_W/2.
//   - Undefined: one step per edge; N = DIVIDEND_W.
//   - Results, handshake, and div-by-zero behaviour identical in both builds; only latency differs.
// TESTING
// - 200/7 -> quotient=28, remainder=4, dbz=0; out_valid 16 cycles after accept (8 with RADIX4_EN).
// - 65535/255 -> quotient=257, remainder=0. 65535/1 -> quotient=65535, remainder=0.
// - 5/9 -> quotient=0, remainder=5.
// - 1234/0 -> quotient=0xFFFF, remainder=0xD2, div_by_zero=1; out_valid 1 cycle after accept.
// - 1000/3 with out_ready=0 for 5 cycles -> quotient=333, remainder=1; outputs stable, in_ready=0 throughout;
//   IDLE on the ready edge.
// - Assert rst_n low mid-CALC -> out_valid=0, in_ready=1 immediately.
//   Next op 100/10 -> quotient=10, remainder=0, no stale data.
// - Random sweep, both builds: quotient*divisor+remainder == dividend; remainder < divisor.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider with valid/ready handshake, one operation in flight.
// Optional build macro RADIX4_EN: two restoring steps per CALC cycle (N = DIVIDEND_W/2).
module seq_restoring_divider #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned PREM_W = DIVISOR_W + 1;
`ifdef RADIX4_EN
  localparam int unsigned N_STEPS = DIVIDEND_W / 2;
`else
  localparam int unsigned N_STEPS = DIVIDEND_W;
`endif
  localparam int unsigned CNT_W = $clog2(N_STEPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVISOR_W-1:0]  prem_q, prem_nxt;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_nxt;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic                  accept_c;
  logic                  finish_c;

  // One restoring step on a guard-bit-extended partial remainder; returns {quotient_bit, new_remainder}.
  function automatic logic [PREM_W-1:0] rstep(input logic [DIVISOR_W-1:0] rem,
                                               input logic                 nbit,
                                               input logic [DIVISOR_W-1:0] d);
    logic [PREM_W-1:0] sh;
    sh = {rem, nbit};
    if (sh >= {1'b0, d}) rstep = {1'b1, DIVISOR_W'(sh - {1'b0, d})};
    else                 rstep = {1'b0, sh[DIVISOR_W-1:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept_c  = 1'b0;
    finish_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c  = 1'b1;
          state_nxt = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(1)) begin
          finish_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-subtract datapath: dividend bits leave the MSB, quotient bits enter the LSB.
  always_comb begin
    logic [PREM_W-1:0] s1;
`ifdef RADIX4_EN
    logic [PREM_W-1:0] s2;
    s1       = rstep(prem_q, dvd_q[DIVIDEND_W-1], dvs_q);
    s2       = rstep(s1[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-2], dvs_q);
    prem_nxt = s2[DIVISOR_W-1:0];
    dvd_nxt  = {dvd_q[DIVIDEND_W-3:0], s1[DIVISOR_W], s2[DIVISOR_W]};
`else
    s1       = rstep(prem_q, dvd_q[DIVIDEND_W-1], dvs_q);
    prem_nxt = s1[DIVISOR_W-1:0];
    dvd_nxt  = {dvd_q[DIVIDEND_W-2:0], s1[DIVISOR_W]};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt_q       <= '0;
      prem_q      <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept_c) begin
        dvd_q       <= dividend;
        dvs_q       <= divisor;
        prem_q      <= '0;
        cnt_q       <= CNT_W'(N_STEPS);
        div_by_zero <= (divisor == '0);
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend[DIVISOR_W-1:0];
        end
      end else if (state_q == CALC) begin
        dvd_q  <= dvd_nxt;
        prem_q <= prem_nxt;
        cnt_q  <= cnt_q - CNT_W'(1);
        if (finish_c) begin
          quotient  <= dvd_nxt;
          remainder <= prem_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed corner cases plus a random sweep against an arithmetic model.
module tb_seq_restoring_divider;
  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;
`ifdef RADIX4_EN
  localparam int N_LAT = DIVIDEND_W / 2;
`else
  localparam int N_LAT = DIVIDEND_W;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [DIVIDEND_W-1:0] dividend, quotient;
  logic [DIVISOR_W-1:0]  divisor, remainder;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, hold out_ready low for 'hold' cycles, then hand the result off.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b, input int hold);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edbz;
    int          lat, w, elat;
    if (b == 0) begin
      eq = 16'hFFFF; er = a[7:0]; edbz = 1'b1; elat = 0;
    end else begin
      eq = 16'(int'(a) / int'(b)); er = 8'(int'(a) % int'(b)); edbz = 1'b0; elat = N_LAT;
    end
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    check({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    tick();
    // Stray requests with different operands while busy must be ignored.
    dividend = 16'($urandom); divisor = 8'($urandom);
    check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    for (int i = 0; i < hold; i++) begin
      check({tag, " hold_quotient"}, 32'(quotient), 32'(eq));
      check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " hold_out_valid"}, 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
    if (b != 0) begin
      check({tag, " identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check({tag, " rem_lt_div"}, 32'(remainder < b), 32'd1);
    end
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, " quotient_holds"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    int          sel;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_op("200/7", 16'd200, 8'd7, 0);
    run_op("65535/255", 16'd65535, 8'd255, 0);
    run_op("65535/1", 16'd65535, 8'd1, 1);
    run_op("5/9", 16'd5, 8'd9, 0);
    run_op("1234/0", 16'd1234, 8'd0, 2);
    run_op("1000/3", 16'd1000, 8'd3, 5);

    // Reset in the middle of a calculation.
    in_valid = 1'b1; dividend = 16'd200; divisor = 8'd7;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset quotient", 32'(quotient), 32'd0);
    check("midreset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_op("100/10", 16'd100, 8'd10, 0);

    for (int k = 0; k < 60; k++) begin
      sel = int'($urandom_range(0, 9));
      ra  = (sel == 9) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if (sel == 0)      rb = 8'd0;
      else if (sel < 4)  rb = 8'($urandom_range(1, 15));
      else               rb = 8'($urandom_range(1, 255));
      run_op("random", ra, rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
